// File: rtl/tilemap_pkg.sv
// Shared definitions for the tilemap fetch sequencer: slot phases, scroll
// register map, layer encoding and the scroll register record.
package tilemap_pkg;

  typedef enum logic [2:0] {
    PH_VRAM_A = 3'd0,
    PH_DATA_A = 3'd1,
    PH_ROM_A0 = 3'd2,
    PH_ROM_A1 = 3'd3,
    PH_VRAM_B = 3'd4,
    PH_DATA_B = 3'd5,
    PH_ROM_B0 = 3'd6,
    PH_ROM_B1 = 3'd7
  } phase_e;

  localparam logic [2:0] REG_XA_LO = 3'd0;
  localparam logic [2:0] REG_XA_HI = 3'd1;
  localparam logic [2:0] REG_YA    = 3'd2;
  localparam logic [2:0] REG_XB_LO = 3'd4;
  localparam logic [2:0] REG_XB_HI = 3'd5;
  localparam logic [2:0] REG_YB    = 3'd6;

  localparam logic LAYER_A = 1'b0;
  localparam logic LAYER_B = 1'b1;

  localparam int LOOKAHEAD_DEFAULT = 16;

  typedef struct packed {
    logic [8:0] x_a;
    logic [7:0] y_a;
    logic [8:0] x_b;
    logic [7:0] y_b;
  } scroll_t;

endpackage

// File: rtl/tilemap_fetch_sequencer_layer_addr.sv
// Per-layer tile coordinate calculation: scrolled, optionally flipped x/y
// reduced to tile column, tile row and line within the tile.
module tile_layer_addr
  import tilemap_pkg::*;
#(
  parameter int LOOKAHEAD = LOOKAHEAD_DEFAULT
) (
  input  logic [5:0] hpos_grp,
  input  logic [7:0] vpos,
  input  logic [8:0] scroll_x,
  input  logic [7:0] scroll_y,
  input  logic       flip,
  output logic [5:0] col,
  output logic [4:0] row,
  output logic [2:0] line
);

  logic [8:0] x_raw;
  logic [8:0] x;
  logic [7:0] y_raw;
  logic [7:0] y;
  logic       unused_x_fine;

  // Both sums wrap naturally at their widths (512 and 256).
  always_comb begin
    x_raw = {hpos_grp, 3'b000} + 9'(LOOKAHEAD) + scroll_x;
    y_raw = vpos + scroll_y;
    x     = flip ? ~x_raw : x_raw;
    y     = flip ? ~y_raw : y_raw;
  end

  assign col           = x[8:3];
  assign row           = y[7:3];
  assign line          = y[2:0];
  assign unused_x_fine = ^x[2:0];

endmodule

// File: rtl/tilemap_fetch_sequencer.sv
// Shares one VRAM port and one tile ROM port between tilemap layers A and B
// in a fixed 8-cycle slot schedule, and owns the pixel counter and scroll registers.
module tilemap_fetch_sequencer
  import tilemap_pkg::*;
#(
  parameter int LOOKAHEAD = 16,
  parameter int VRAM_AW   = 12,
  parameter int ROM_AW    = 16
) (
  input  logic               CLK_6M,
  input  logic               RST,
  input  logic               HSTART,
  input  logic [7:0]         VPOS,
  input  logic               FLIP,
  input  logic               CPU_WE,
  input  logic [2:0]         CPU_A,
  input  logic [7:0]         CPU_D,
  output logic [VRAM_AW-1:0] VRAM_ADDR,
  input  logic [15:0]        VRAM_DATA,
  output logic [ROM_AW-1:0]  ROM_ADDR,
  output logic               LAYER,
  output logic               LOAD_A,
  output logic               LOAD_B,
  output logic [8:0]         HPOS
);

  logic [8:0]         hpos_q, hpos_d;
  logic               active_q, active_d;
  scroll_t            scroll_q, scroll_d;
  scroll_t            shadow_q, shadow_d;
  logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
  logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
  logic               layer_q, layer_d;
  logic               load_a_q, load_a_d;
  logic               load_b_q, load_b_d;
  logic [2:0]         bank_a_q, bank_a_d, bank_b_q, bank_b_d;
  logic [7:0]         code_a_q, code_a_d, code_b_q, code_b_d;

  logic       advance;
  phase_e     phase_d;
  logic [5:0] col_a, col_b;
  logic [4:0] row_a, row_b;
  logic [2:0] line_a, line_b;
  logic [2:0] fine_a, fine_b;
  logic       unused_attr_hi;

  assign advance        = active_q | HSTART;
  assign phase_d        = phase_e'(hpos_d[2:0]);
  assign unused_attr_hi = ^VRAM_DATA[15:11];

  // Coordinates are evaluated for the cycle being entered, so every output
  // register lands on its slot already holding that slot's value.
  tile_layer_addr #(.LOOKAHEAD(LOOKAHEAD)) u_addr_a (
    .hpos_grp(hpos_d[8:3]), .vpos(VPOS), .scroll_x(shadow_d.x_a),
    .scroll_y(shadow_d.y_a), .flip(FLIP), .col(col_a), .row(row_a), .line(line_a)
  );

  tile_layer_addr #(.LOOKAHEAD(LOOKAHEAD)) u_addr_b (
    .hpos_grp(hpos_d[8:3]), .vpos(VPOS), .scroll_x(shadow_d.x_b),
    .scroll_y(shadow_d.y_b), .flip(FLIP), .col(col_b), .row(row_b), .line(line_b)
  );

  always_ff @(posedge CLK_6M) begin
    if (RST) begin
      hpos_q      <= '0;
      active_q    <= 1'b0;
      scroll_q    <= '0;
      shadow_q    <= '0;
      vram_addr_q <= '0;
      rom_addr_q  <= '0;
      layer_q     <= LAYER_A;
      load_a_q    <= 1'b0;
      load_b_q    <= 1'b0;
      bank_a_q    <= '0;
      code_a_q    <= '0;
      bank_b_q    <= '0;
      code_b_q    <= '0;
    end else begin
      hpos_q      <= hpos_d;
      active_q    <= active_d;
      scroll_q    <= scroll_d;
      shadow_q    <= shadow_d;
      vram_addr_q <= vram_addr_d;
      rom_addr_q  <= rom_addr_d;
      layer_q     <= layer_d;
      load_a_q    <= load_a_d;
      load_b_q    <= load_b_d;
      bank_a_q    <= bank_a_d;
      code_a_q    <= code_a_d;
      bank_b_q    <= bank_b_d;
      code_b_q    <= code_b_d;
    end
  end

  // After reset the counter stays parked at 0 until the first line start.
  always_comb begin
    active_d = advance;
    hpos_d   = hpos_q;
    if (HSTART)        hpos_d = '0;
    else if (active_q) hpos_d = hpos_q + 9'd1;

    scroll_d = scroll_q;
    if (CPU_WE) begin
      case (CPU_A)
        REG_XA_LO: scroll_d.x_a[7:0] = CPU_D;
        REG_XA_HI: scroll_d.x_a[8]   = CPU_D[0];
        REG_YA:    scroll_d.y_a      = CPU_D;
        REG_XB_LO: scroll_d.x_b[7:0] = CPU_D;
        REG_XB_HI: scroll_d.x_b[8]   = CPU_D[0];
        REG_YB:    scroll_d.y_b      = CPU_D;
        default:   ;
      endcase
    end

    // The shadow takes the pre-write scroll value, so a write in the phase-0
    // cycle only shows up one group later.
    shadow_d = shadow_q;
    if (advance && phase_d == PH_VRAM_A) shadow_d = scroll_q;
  end

  always_comb begin
    vram_addr_d = vram_addr_q;
    rom_addr_d  = rom_addr_q;
    bank_a_d    = bank_a_q;
    code_a_d    = code_a_q;
    bank_b_d    = bank_b_q;
    code_b_d    = code_b_q;
    layer_d     = layer_q;
    fine_a      = hpos_d[2:0] + shadow_d.x_a[2:0];
    fine_b      = hpos_d[2:0] + shadow_d.x_b[2:0];
    load_a_d    = advance && (fine_a == 3'd7);
    load_b_d    = advance && (fine_b == 3'd7);
    if (advance) begin
      layer_d = hpos_d[2];
      case (phase_d)
        PH_VRAM_A: vram_addr_d = {LAYER_A, row_a, col_a};
        PH_ROM_A0: begin
          bank_a_d   = VRAM_DATA[10:8];
          code_a_d   = VRAM_DATA[7:0];
          rom_addr_d = {VRAM_DATA[10:8], VRAM_DATA[7:0], line_a, 2'b00};
        end
        PH_ROM_A1: rom_addr_d = {bank_a_q, code_a_q, line_a, 2'b10};
        PH_VRAM_B: vram_addr_d = {LAYER_B, row_b, col_b};
        PH_ROM_B0: begin
          bank_b_d   = VRAM_DATA[10:8];
          code_b_d   = VRAM_DATA[7:0];
          rom_addr_d = {VRAM_DATA[10:8], VRAM_DATA[7:0], line_b, 2'b00};
        end
        PH_ROM_B1: rom_addr_d = {bank_b_q, code_b_q, line_b, 2'b10};
        default:   ;
      endcase
    end
  end

  assign VRAM_ADDR = vram_addr_q;
  assign ROM_ADDR  = rom_addr_q;
  assign LAYER     = layer_q;
  assign LOAD_A    = load_a_q;
  assign LOAD_B    = load_b_q;
  assign HPOS      = hpos_q;

endmodule
